// File: rtl/mux8_scan_ctrl.sv
// Scan driver for an 8:1 mux: walks the select lines over a held byte, samples Y, streams and reassembles it.
// Build option: define MUX8_SCAN_MSB_FIRST_EN to scan index 7 down to 0 (default scans 0 up to 7).
module mux8_scan_ctrl #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] I,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       enable,
  input  logic       Y,
  output logic       ser_valid,
  output logic       ser_bit,
  output logic       ser_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

`ifdef MUX8_SCAN_MSB_FIRST_EN
  localparam logic [2:0] START_IDX = 3'd7;
  localparam logic [2:0] LAST_IDX  = 3'd0;
`else
  localparam logic [2:0] START_IDX = 3'd0;
  localparam logic [2:0] LAST_IDX  = 3'd7;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [7:0]      data_nxt, out_data_nxt;
  logic            in_ready_nxt, enable_nxt, out_valid_nxt;
  logic            ser_valid_nxt, ser_bit_nxt, ser_last_nxt;

  assign {s2, s1, s0} = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      hold_cnt  <= '0;
      I         <= 8'h00;
      in_ready  <= 1'b0;
      enable    <= 1'b0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_last  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      hold_cnt  <= hold_nxt;
      I         <= data_nxt;
      in_ready  <= in_ready_nxt;
      enable    <= enable_nxt;
      ser_valid <= ser_valid_nxt;
      ser_bit   <= ser_bit_nxt;
      ser_last  <= ser_last_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    hold_nxt      = hold_cnt;
    data_nxt      = I;
    in_ready_nxt  = in_ready;
    enable_nxt    = enable;
    ser_valid_nxt = 1'b0;
    ser_bit_nxt   = ser_bit;
    ser_last_nxt  = 1'b0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;

    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          data_nxt     = in_data;
          idx_nxt      = START_IDX;
          enable_nxt   = 1'b1;
          hold_nxt     = '0;
          out_data_nxt = 8'h00;
          in_ready_nxt = 1'b0;
          state_nxt    = SCAN;
        end
      end

      SCAN: begin
        // Y is sampled only on the closing edge of each hold window, so I and select never move mid-window.
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt          = '0;
          out_data_nxt[idx] = Y;
          ser_bit_nxt       = Y;
          ser_valid_nxt     = 1'b1;
          if (idx == LAST_IDX) begin
            ser_last_nxt  = 1'b1;
            enable_nxt    = 1'b0;
            out_valid_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
`ifdef MUX8_SCAN_MSB_FIRST_EN
            idx_nxt = idx - 3'd1;
`else
            idx_nxt = idx + 3'd1;
`endif
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_ONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
